// File: rtl/reorder_buffer_param_if.sv
// Handshake and data bundle between the core pipeline (master) and the reorder buffer (slave).
interface reorder_buffer_param_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_CDB    = 2,
    parameter int XLEN       = 32
);
    localparam int TAG_W = DEPTH_LOG2;

    logic                    issue_valid;
    logic [4:0]              issue_rd;
    logic                    issue_is_store;
    logic                    issue_is_branch;
    logic [XLEN-1:0]         issue_pc;
    logic [XLEN-1:0]         issue_pred_pc;
    logic [TAG_W-1:0]        issue_tag;
    logic                    full;
    logic                    empty;
    logic [TAG_W:0]          count;
    logic [NUM_CDB-1:0]      wb_valid;
    logic [NUM_CDB*TAG_W-1:0] wb_tag;
    logic [NUM_CDB*XLEN-1:0] wb_value;
    logic [NUM_CDB*XLEN-1:0] wb_next_pc;
    logic                    commit_valid;
    logic [TAG_W-1:0]        commit_tag;
    logic [4:0]              commit_rd;
    logic [XLEN-1:0]         commit_value;
    logic [XLEN-1:0]         commit_pc;
    logic                    store_commit;
    logic                    store_done;
    logic                    mispredict;
    logic [XLEN-1:0]         redirect_pc;

    modport master (
        output issue_valid, issue_rd, issue_is_store, issue_is_branch, issue_pc, issue_pred_pc,
        output wb_valid, wb_tag, wb_value, wb_next_pc, store_done,
        input  issue_tag, full, empty, count,
        input  commit_valid, commit_tag, commit_rd, commit_value, commit_pc,
        input  store_commit, mispredict, redirect_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_is_store, issue_is_branch, issue_pc, issue_pred_pc,
        input  wb_valid, wb_tag, wb_value, wb_next_pc, store_done,
        output issue_tag, full, empty, count,
        output commit_valid, commit_tag, commit_rd, commit_value, commit_pc,
        output store_commit, mispredict, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer_param.sv
// In-order commit reorder buffer: circular entry store, multi-channel writeback,
// store handshake with the memory controller and branch-mispredict rollback.
module reorder_buffer_param #(
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_CDB    = 2,
    parameter int XLEN       = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    reorder_buffer_param_if.slave  rob
);
    localparam int TAG_W = DEPTH_LOG2;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);

    typedef enum logic {IDLE, WAIT_STORE} state_t;
    state_t state;

    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count;
    logic [DEPTH-1:0] ent_valid, ent_ready, ent_store, ent_branch;
    logic [4:0]       ent_rd    [DEPTH];
    logic [XLEN-1:0]  ent_pc    [DEPTH];
    logic [XLEN-1:0]  ent_pred  [DEPTH];
    logic [XLEN-1:0]  ent_value [DEPTH];
    logic [XLEN-1:0]  ent_npc   [DEPTH];

    logic             commit_valid_q, store_commit_q, mispredict_q;
    logic [TAG_W-1:0] commit_tag_q;
    logic [4:0]       commit_rd_q;
    logic [XLEN-1:0]  commit_value_q, commit_pc_q, redirect_pc_q;

    logic             full_w, issue_fire, commit_fire, commit_rollback;
    logic [TAG_W-1:0] wb_tag_a   [NUM_CDB];
    logic [XLEN-1:0]  wb_value_a [NUM_CDB];
    logic [XLEN-1:0]  wb_npc_a   [NUM_CDB];

    always_comb begin
        full_w          = (count == DEPTH_CNT);
        issue_fire      = rob.issue_valid & ~full_w;
        commit_fire     = (state == IDLE) & ent_valid[head] & ent_ready[head];
        commit_rollback = commit_fire & ent_branch[head] & (ent_npc[head] != ent_pred[head]);
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            wb_tag_a[k]   = rob.wb_tag[k*TAG_W +: TAG_W];
            wb_value_a[k] = rob.wb_value[k*XLEN +: XLEN];
            wb_npc_a[k]   = rob.wb_next_pc[k*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ent_valid      <= '0;
            ent_ready      <= '0;
            commit_valid_q <= 1'b0;
            store_commit_q <= 1'b0;
            mispredict_q   <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_pc_q    <= '0;
            redirect_pc_q  <= '0;
        end else begin
            // store completion is observed even while paused or flushing
            if (state == WAIT_STORE && rob.store_done)
                state <= IDLE;

            commit_valid_q <= 1'b0;
            store_commit_q <= 1'b0;
            mispredict_q   <= 1'b0;

            if (rdy_in && flush_in) begin
                ent_valid <= '0;
                ent_ready <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
            end else if (rdy_in) begin
                // descending order so the lowest channel's write lands last and wins
                for (int unsigned i = NUM_CDB; i > 0; i--) begin
                    if (rob.wb_valid[i-1] && ent_valid[wb_tag_a[i-1]]) begin
                        ent_ready[wb_tag_a[i-1]] <= 1'b1;
                        ent_value[wb_tag_a[i-1]] <= wb_value_a[i-1];
                        ent_npc[wb_tag_a[i-1]]   <= wb_npc_a[i-1];
                    end
                end

                if (commit_fire) begin
                    commit_valid_q  <= 1'b1;
                    commit_tag_q    <= head;
                    commit_rd_q     <= ent_rd[head];
                    commit_value_q  <= ent_value[head];
                    commit_pc_q     <= ent_pc[head];
                    ent_valid[head] <= 1'b0;
                    ent_ready[head] <= 1'b0;
                    head            <= head + 1'b1;
                    if (ent_store[head]) begin
                        store_commit_q <= 1'b1;
                        state          <= WAIT_STORE;
                    end
                end

                if (issue_fire && !commit_rollback) begin
                    ent_valid[tail]  <= 1'b1;
                    ent_ready[tail]  <= 1'b0;
                    ent_store[tail]  <= rob.issue_is_store;
                    ent_branch[tail] <= rob.issue_is_branch;
                    ent_rd[tail]     <= rob.issue_rd;
                    ent_pc[tail]     <= rob.issue_pc;
                    ent_pred[tail]   <= rob.issue_pred_pc;
                    tail             <= tail + 1'b1;
                end

                if (commit_rollback) begin
                    mispredict_q  <= 1'b1;
                    redirect_pc_q <= ent_npc[head];
                    ent_valid     <= '0;
                    ent_ready     <= '0;
                    head          <= '0;
                    tail          <= '0;
                    count         <= '0;
                end else begin
                    count <= count + {{TAG_W{1'b0}}, issue_fire} - {{TAG_W{1'b0}}, commit_fire};
                end
            end
        end
    end

    assign rob.issue_tag    = tail;
    assign rob.full         = full_w;
    assign rob.empty        = (count == '0);
    assign rob.count        = count;
    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_tag   = commit_tag_q;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_value = commit_value_q;
    assign rob.commit_pc    = commit_pc_q;
    assign rob.store_commit = store_commit_q;
    assign rob.mispredict   = mispredict_q;
    assign rob.redirect_pc  = redirect_pc_q;
endmodule

// File: tb/tb_reorder_buffer_param.sv
// Randomized and directed bench for reorder_buffer_param against a queue-based program-order model.
module tb_reorder_buffer_param;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    always #5 clk = ~clk;

    reorder_buffer_param_if #(.DEPTH_LOG2(4), .NUM_CDB(2), .XLEN(32)) bus ();

    reorder_buffer_param #(.DEPTH_LOG2(4), .NUM_CDB(2), .XLEN(32)) dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .rdy_in  (rdy),
        .flush_in(flush),
        .rob     (bus)
    );

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          st, br, rdy;
        logic [31:0] pc, pred, val, npc;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    bit          m_wait;
    bit          e_cv, e_sc, e_mp;
    int          e_tag;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_pc, e_redir;
    int          clog[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Program-order model: entries live in a queue, writebacks find their entry by tag.
    task automatic model_step();
        bit   nw, do_commit, rollback;
        bit   [DEPTH-1:0] hit;
        int   sz;
        ent_t h;
        if (rst) begin
            q.delete(); m_tail = 0; m_wait = 0;
            e_cv = 0; e_sc = 0; e_mp = 0; e_tag = 0; e_rd = 0; e_val = 0; e_pc = 0; e_redir = 0;
            return;
        end
        nw = m_wait && bus.store_done ? 1'b0 : m_wait;
        e_cv = 0; e_sc = 0; e_mp = 0;
        if (!rdy) begin m_wait = nw; return; end
        if (flush) begin q.delete(); m_tail = 0; m_wait = nw; return; end
        sz = q.size();
        do_commit = !m_wait && sz > 0 && q[0].rdy;
        rollback  = 0;
        if (do_commit) begin
            h = q[0];
            e_cv = 1; e_tag = h.tag; e_rd = h.rd; e_val = h.val; e_pc = h.pc;
            if (h.st) begin e_sc = 1; nw = 1; end
            if (h.br && h.npc != h.pred) begin e_mp = 1; e_redir = h.npc; rollback = 1; end
        end
        hit = '0;
        for (int k = 0; k < 2; k++) begin
            int t;
            t = int'(bus.wb_tag[k*4 +: 4]);
            if (bus.wb_valid[k] && !hit[t]) begin
                hit[t] = 1;
                foreach (q[j]) if (q[j].tag == t) begin
                    q[j].rdy = 1; q[j].val = bus.wb_value[k*32 +: 32]; q[j].npc = bus.wb_next_pc[k*32 +: 32];
                end
            end
        end
        if (do_commit) void'(q.pop_front());
        if (rollback) begin
            q.delete(); m_tail = 0;
        end else if (bus.issue_valid && sz < DEPTH) begin
            q.push_back('{tag: m_tail, rd: bus.issue_rd, st: bus.issue_is_store, br: bus.issue_is_branch,
                          rdy: 0, pc: bus.issue_pc, pred: bus.issue_pred_pc, val: 0, npc: 0});
            m_tail = (m_tail + 1) % DEPTH;
        end
        m_wait = nw;
    endtask

    task automatic compare_all();
        check_eq("commit_valid", bus.commit_valid, e_cv);
        check_eq("store_commit", bus.store_commit, e_sc);
        check_eq("mispredict", bus.mispredict, e_mp);
        check_eq("redirect_pc", bus.redirect_pc, e_redir);
        check_eq("commit_tag", bus.commit_tag, e_tag);
        check_eq("commit_rd", bus.commit_rd, e_rd);
        check_eq("commit_value", bus.commit_value, e_val);
        check_eq("commit_pc", bus.commit_pc, e_pc);
        check_eq("count", bus.count, q.size());
        check_eq("full", bus.full, q.size() == DEPTH);
        check_eq("empty", bus.empty, q.size() == 0);
        check_eq("issue_tag", bus.issue_tag, m_tail);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (bus.commit_valid) clog.push_back(int'(bus.commit_tag));
    endtask

    task automatic clear_in();
        rst = 0; rdy = 1; flush = 0;
        bus.issue_valid = 0; bus.issue_rd = 0; bus.issue_is_store = 0; bus.issue_is_branch = 0;
        bus.issue_pc = 0; bus.issue_pred_pc = 0;
        bus.wb_valid = 0; bus.wb_tag = 0; bus.wb_value = 0; bus.wb_next_pc = 0; bus.store_done = 0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input bit st, input bit br,
                             input logic [31:0] pc, input logic [31:0] pred);
        bus.issue_valid = 1; bus.issue_rd = rd; bus.issue_is_store = st; bus.issue_is_branch = br;
        bus.issue_pc = pc; bus.issue_pred_pc = pred;
    endtask

    task automatic set_wb(input int ch, input logic [3:0] tag, input logic [31:0] val, input logic [31:0] npc);
        bus.wb_valid[ch] = 1; bus.wb_tag[ch*4 +: 4] = tag;
        bus.wb_value[ch*32 +: 32] = val; bus.wb_next_pc[ch*32 +: 32] = npc;
    endtask

    task automatic do_reset();
        clear_in(); rst = 1; tick(); rst = 0;
    endtask

    initial begin
        int snap;
        bit seen;
        clear_in();
        do_reset();
        check_eq("reset_empty", bus.empty, 1);
        check_eq("reset_count", bus.count, 0);

        // fill all sixteen entries, then a seventeenth issue is ignored
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(5'(i), 0, 0, 32'h1000 + 32'(i*4), 32'h1004 + 32'(i*4)); tick();
        end
        check_eq("fill_full", bus.full, 1);
        check_eq("fill_count", bus.count, 16);
        tick();
        check_eq("over_count", bus.count, 16);
        check_eq("over_tail", bus.issue_tag, 0);

        // out-of-order writeback, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) begin set_issue(5'(i+1), 0, 0, 32'h20 + 32'(i*4), 32'h24 + 32'(i*4)); tick(); end
        clear_in(); set_wb(0, 2, 32'h22, 32'h2c); tick();
        clear_in(); set_wb(0, 0, 32'h20, 32'h24); tick();
        clog.delete();
        clear_in(); set_wb(1, 1, 32'h21, 32'h28); tick();
        for (int i = 0; i < 4; i++) tick();
        check_eq("order_n", clog.size(), 3);
        if (clog.size() == 3) begin
            check_eq("order_0", clog[0], 0); check_eq("order_1", clog[1], 1); check_eq("order_2", clog[2], 2);
        end

        // store blocks later commits until store_done
        do_reset();
        set_issue(5'd3, 1, 0, 32'h40, 32'h44); tick();
        clear_in(); set_wb(0, 0, 32'hAD, 32'h44); set_issue(5'd4, 0, 0, 32'h44, 32'h48); tick();
        clear_in(); set_wb(0, 1, 32'h55, 32'h48); tick();
        check_eq("st_commit", bus.store_commit, 1);
        check_eq("st_cvalid", bus.commit_valid, 1);
        clear_in(); tick(); tick(); tick();
        check_eq("st_hold", bus.commit_valid, 0);
        bus.store_done = 1; tick();
        check_eq("st_done_cyc", bus.commit_valid, 0);
        clear_in(); tick();
        check_eq("st_next", bus.commit_valid, 1);
        check_eq("st_next_tag", bus.commit_tag, 1);

        // branch mispredict with a simultaneous issue
        do_reset();
        set_issue(5'd0, 0, 1, 32'h40, 32'h100); tick();
        clear_in(); set_wb(0, 0, 32'h0, 32'h200); tick();
        clear_in(); set_issue(5'd9, 0, 0, 32'h44, 32'h48); tick();
        check_eq("br_mp", bus.mispredict, 1);
        check_eq("br_redir", bus.redirect_pc, 32'h200);
        check_eq("br_count", bus.count, 0);
        clear_in(); tick();
        check_eq("br_pulse", bus.mispredict, 0);

        // same-tag dual writeback and a three-cycle pause
        do_reset();
        for (int i = 0; i < 4; i++) begin set_issue(5'(i+8), 0, 0, 32'h80 + 32'(i*4), 32'h84 + 32'(i*4)); tick(); end
        clear_in(); set_wb(0, 3, 32'hA, 32'h90); set_wb(1, 3, 32'hB, 32'h90); tick();
        clear_in(); set_wb(0, 0, 32'h1, 32'h84); set_wb(1, 1, 32'h2, 32'h88); tick();
        clear_in(); set_wb(0, 2, 32'h3, 32'h8c); tick();
        snap = int'(bus.count);
        clear_in(); rdy = 0; set_issue(5'd1, 0, 0, 32'h0, 32'h4); set_wb(0, 3, 32'hC, 32'h0);
        for (int i = 0; i < 3; i++) begin tick(); check_eq("pause_cv", bus.commit_valid, 0); end
        check_eq("pause_count", bus.count, snap);
        clear_in();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.commit_valid && bus.commit_tag == 4'd3) begin seen = 1; check_eq("dual_wb_val", bus.commit_value, 32'hA); end
        end
        check_eq("dual_wb_seen", seen, 1);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            clear_in();
            rst   = ($urandom % 400) == 0;
            rdy   = ($urandom % 10) != 0;
            flush = ($urandom % 60) == 0;
            if ($urandom % 2) begin
                int kind;
                logic [31:0] pc;
                kind = $urandom % 5;
                pc = $urandom & 32'hFFFF_FFFC;
                set_issue(5'($urandom), kind == 0, kind == 1, pc, pc + 4);
            end
            for (int k = 0; k < 2; k++) if ($urandom % 5 < 2) begin
                logic [3:0]  t;
                logic [31:0] npc;
                t = 4'($urandom); npc = $urandom;
                if (q.size() > 0 && $urandom % 5 != 0) begin
                    int idx;
                    idx = $urandom_range(0, q.size() - 1);
                    t = 4'(q[idx].tag);
                    if ($urandom % 6 != 0) npc = q[idx].pred;
                end
                set_wb(k, t, $urandom, npc);
            end
            bus.store_done = m_wait ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
